// File: rtl/ysyx_22050019_mdu_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit.
// Contents:
//   XLEN        - default operand/result width
//   MDU_*       - 4-bit operation encodings (values 10..15 are reserved)
//   mdu_state_e - sequencer states
package ysyx_22050019_mdu_pkg;

  localparam int XLEN = 64;

  localparam logic [3:0] MDU_MUL   = 4'd0;
  localparam logic [3:0] MDU_MULW  = 4'd1;
  localparam logic [3:0] MDU_DIV   = 4'd2;
  localparam logic [3:0] MDU_DIVU  = 4'd3;
  localparam logic [3:0] MDU_DIVW  = 4'd4;
  localparam logic [3:0] MDU_DIVUW = 4'd5;
  localparam logic [3:0] MDU_REM   = 4'd6;
  localparam logic [3:0] MDU_REMU  = 4'd7;
  localparam logic [3:0] MDU_REMW  = 4'd8;
  localparam logic [3:0] MDU_REMUW = 4'd9;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PREP  = 3'd1,
    CALC  = 3'd2,
    FIXUP = 3'd3,
    DONE  = 3'd4
  } mdu_state_e;

endpackage

// File: rtl/ysyx_22050019_mdu_step.sv
// One iteration of the MDU datapath, purely combinational.
// Ports:
//   is_div_i - 1: restoring-divide step, 0: shift-add multiply step
//   a_i/a_o  - multiplicand (mul) or dividend/quotient shift register (div)
//   b_i/b_o  - multiplier (mul) or divisor (div)
//   acc_i/acc_o - product accumulator (mul) or partial remainder (div)
module ysyx_22050019_mdu_step #(
  parameter int XLEN = 64
) (
  input  logic            is_div_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [XLEN-1:0] acc_i,
  output logic [XLEN-1:0] a_o,
  output logic [XLEN-1:0] b_o,
  output logic [XLEN-1:0] acc_o
);
  import ysyx_22050019_mdu_pkg::*;

  // The shifted remainder keeps its carry-out bit so that divisors with
  // the MSB set still compare correctly in unsigned 64-bit division.
  logic [XLEN:0] part;
  logic          ge;

  assign part = {acc_i, a_i[XLEN-1]};
  assign ge   = (part >= {1'b0, b_i});

  always_comb begin
    a_o   = a_i;
    b_o   = b_i;
    acc_o = acc_i;
    if (is_div_i) begin
      // Quotient bits enter at the LSB as dividend bits leave at the MSB.
      a_o   = {a_i[XLEN-2:0], ge};
      acc_o = ge ? (part[XLEN-1:0] - b_i) : part[XLEN-1:0];
    end else begin
      acc_o = acc_i + (b_i[0] ? a_i : '0);
      a_o   = a_i << 1;
      b_o   = b_i >> 1;
    end
  end

endmodule

// File: rtl/ysyx_22050019_mdu.sv
// Multi-cycle RV64M multiply/divide unit: shift-add multiplier and
// restoring divider sharing one iteration datapath.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid/in_ready   - request handshake; op, op_1, op_2 latched on accept
//   flush               - abort the in-flight operation
//   out_valid/out_ready - result handshake; result held until accepted
//   result              - registered result (word ops sign-extended)
//   busy                - high whenever the sequencer is not IDLE
module ysyx_22050019_mdu #(
  parameter int XLEN = ysyx_22050019_mdu_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] op_1,
  input  logic [XLEN-1:0] op_2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  import ysyx_22050019_mdu_pkg::*;

  localparam int CW = $clog2(XLEN);

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
    return {{(XLEN-32){1'b0}}, v};
  endfunction

  mdu_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_last;
  logic [3:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, res_q, res_d;
  logic            qs_q, qs_d, rs_q, rs_d, ov_q, ov_d;

  logic            is_word, is_sgn, is_div, is_rem, is_mul;
  logic            s1, s2, dz, ovf;
  logic [XLEN-1:0] x_w, y_w, ax_w, ay_w, min_w, spec_w;
  logic [XLEN-1:0] qn_w, rn_w, sel_w, fix_w;
  logic [XLEN-1:0] step_a, step_b, step_acc;

  assign is_word = op_q inside {MDU_MULW, MDU_DIVW, MDU_DIVUW, MDU_REMW, MDU_REMUW};
  assign is_sgn  = op_q inside {MDU_DIV, MDU_DIVW, MDU_REM, MDU_REMW};
  assign is_rem  = op_q inside {MDU_REM, MDU_REMU, MDU_REMW, MDU_REMUW};
  assign is_div  = op_q inside {MDU_DIV, MDU_DIVU, MDU_DIVW, MDU_DIVUW,
                                MDU_REM, MDU_REMU, MDU_REMW, MDU_REMUW};
  assign is_mul  = op_q inside {MDU_MUL, MDU_MULW};

  // Operand preparation from the raw latched operands (used in PREP).
  assign x_w  = is_word ? (is_sgn ? sext32(a_q[31:0]) : zext32(a_q[31:0])) : a_q;
  assign y_w  = is_word ? (is_sgn ? sext32(b_q[31:0]) : zext32(b_q[31:0])) : b_q;
  assign s1   = is_sgn & x_w[XLEN-1];
  assign s2   = is_sgn & y_w[XLEN-1];
  assign ax_w = s1 ? -x_w : x_w;
  assign ay_w = s2 ? -y_w : y_w;

  // Most-negative value at the op width, already sign-extended to XLEN.
  assign min_w = is_word ? {{(XLEN-31){1'b1}}, {31{1'b0}}}
                         : {1'b1, {(XLEN-1){1'b0}}};
  assign dz    = is_div & (y_w == '0);
  assign ovf   = is_sgn & (x_w == min_w) & (y_w == '1);

  always_comb begin
    spec_w = '0;
    if (dz) begin
      if (is_rem) spec_w = is_word ? sext32(a_q[31:0]) : a_q;
      else        spec_w = '1;
    end else if (ovf) begin
      spec_w = is_rem ? '0 : min_w;
    end
  end

  // Sign correction and result selection (used in FIXUP).
  assign qn_w  = qs_q ? -a_q : a_q;
  assign rn_w  = rs_q ? -acc_q : acc_q;
  assign sel_w = is_mul ? acc_q : (is_rem ? rn_w : (is_div ? qn_w : '0));
  assign fix_w = is_word ? sext32(sel_w[31:0]) : sel_w;

  assign cnt_last = is_word ? CW'(31) : CW'(XLEN-1);

  ysyx_22050019_mdu_step #(.XLEN(XLEN)) u_step (
    .is_div_i (is_div),
    .a_i      (a_q),
    .b_i      (b_q),
    .acc_i    (acc_q),
    .a_o      (step_a),
    .b_o      (step_b),
    .acc_o    (step_acc)
  );

  assign in_ready  = (state_q == IDLE) & ~flush & ~rst;
  assign busy      = (state_q != IDLE);
  assign out_valid = ov_q;
  assign result    = res_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    qs_d    = qs_q;
    rs_d    = rs_q;
    res_d   = res_q;
    ov_d    = ov_q;
    case (state_q)
      IDLE: begin
        if (in_valid & in_ready) begin
          op_d    = op;
          a_d     = op_1;
          b_d     = op_2;
          state_d = PREP;
        end
      end
      PREP: begin
        cnt_d = '0;
        acc_d = '0;
        qs_d  = s1 ^ s2;
        rs_d  = s1;
        if (dz | ovf) begin
          res_d   = spec_w;
          ov_d    = 1'b1;
          state_d = DONE;
        end else begin
          // Word dividends are left-aligned so the divider always consumes
          // from bit XLEN-1; after 32 steps the quotient sits in a[31:0].
          if (is_div) begin
            a_d = is_word ? {ax_w[31:0], {(XLEN-32){1'b0}}} : ax_w;
            b_d = ay_w;
          end else begin
            a_d = x_w;
            b_d = y_w;
          end
          state_d = CALC;
        end
      end
      CALC: begin
        a_d   = step_a;
        b_d   = step_b;
        acc_d = step_acc;
        if (cnt_q == cnt_last) state_d = FIXUP;
        else                   cnt_d   = cnt_q + CW'(1);
      end
      FIXUP: begin
        res_d   = fix_w;
        ov_d    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      ov_d    = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      ov_q    <= ov_d;
    end
    op_q  <= op_d;
    a_q   <= a_d;
    b_q   <= b_d;
    acc_q <= acc_d;
    qs_q  <= qs_d;
    rs_q  <= rs_d;
  end

endmodule

// File: tb/tb_ysyx_22050019_mdu.sv
module tb_ysyx_22050019_mdu;
  import ysyx_22050019_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready, busy;
  logic [3:0]  op;
  logic [63:0] op_1, op_2, result;

  int n_checks = 0;
  int n_fail   = 0;

  ysyx_22050019_mdu #(.XLEN(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .op_1      (op_1),
    .op_2      (op_2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Arithmetic reference following the RISC-V M-extension rules.
  function automatic logic [63:0] ref_mdu(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
    longint      sa, sb;
    int          wa, wb, wq;
    logic [31:0] ua, ub, p;
    logic [63:0] mn;
    sa = a; sb = b; ua = a[31:0]; ub = b[31:0]; wa = ua; wb = ub;
    mn = 64'h8000_0000_0000_0000;
    case (o)
      MDU_MUL:  return a * b;
      MDU_MULW: begin p = ua * ub; return sx32(p); end
      MDU_DIV: begin
        if (b == 0) return '1;
        if (a == mn && b == '1) return mn;
        return sa / sb;
      end
      MDU_DIVU: begin
        if (b == 0) return '1;
        return a / b;
      end
      MDU_DIVW: begin
        if (ub == 0) return '1;
        if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) return sx32(32'h8000_0000);
        wq = wa / wb; return sx32(wq);
      end
      MDU_DIVUW: begin
        if (ub == 0) return '1;
        p = ua / ub; return sx32(p);
      end
      MDU_REM: begin
        if (b == 0) return a;
        if (a == mn && b == '1) return 0;
        return sa % sb;
      end
      MDU_REMU: begin
        if (b == 0) return a;
        return a % b;
      end
      MDU_REMW: begin
        if (ub == 0) return sx32(ua);
        if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) return 0;
        wq = wa % wb; return sx32(wq);
      end
      MDU_REMUW: begin
        if (ub == 0) return sx32(ua);
        p = ua % ub; return sx32(p);
      end
      default: return 0;
    endcase
  endfunction

  // Cycles from the accept edge to the first cycle with out_valid.
  function automatic int ref_lat(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
    bit word, sgn, dv;
    word = (o == MDU_MULW) || (o == MDU_DIVW) || (o == MDU_DIVUW) || (o == MDU_REMW) || (o == MDU_REMUW);
    sgn  = (o == MDU_DIV) || (o == MDU_DIVW) || (o == MDU_REM) || (o == MDU_REMW);
    dv   = (o >= 4'd2) && (o <= 4'd9);
    if (dv) begin
      if (word) begin
        if (b[31:0] == 0) return 2;
        if (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 2;
      end else begin
        if (b == 0) return 2;
        if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) return 2;
      end
    end
    return word ? 35 : 67;
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h0000_0000_8000_0000;
      4: return 64'h0000_0000_FFFF_FFFF;
      5: return 64'($urandom_range(0, 15));
      6: return sx32($urandom());
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  // Called at a negedge; returns just after the accepting posedge.
  task automatic issue(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
    for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
    in_valid = 1'b1; op = o; op_1 = a; op_2 = b;
    @(posedge clk);
  endtask

  // Issues one op, waits for the result, completes the handshake; ends at a negedge.
  task automatic run_op(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] r, output int lat);
    issue(o, a, b);
    lat = -1;
    r   = 'x;
    for (int k = 1; k <= 150; k++) begin
      @(negedge clk);
      if (k == 1) in_valid = 1'b0;
      if (out_valid) begin lat = k; r = result; break; end
    end
    if (lat > 0) begin
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (result !== 64'd0) begin n_fail++; $display("FAIL reset_result got %h want 0", result); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
  endtask

  typedef struct {
    logic [3:0]  o;
    logic [63:0] a, b, exp;
    int          lat;
  } vec_t;

  task automatic test_directed();
    vec_t        v[10];
    logic [63:0] r;
    int          lat;
    v[0] = '{MDU_DIV,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 67};
    v[1] = '{MDU_REM,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 67};
    v[2] = '{MDU_DIVU,  64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2};
    v[3] = '{MDU_REMU,  64'h1234, 64'd0, 64'h1234, 2};
    v[4] = '{MDU_REMW,  64'h8000_0001, 64'd0, 64'hFFFF_FFFF_8000_0001, 2};
    v[5] = '{MDU_DIV,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 2};
    v[6] = '{MDU_REM,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 2};
    v[7] = '{MDU_DIVW,  64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 2};
    v[8] = '{MDU_MULW,  64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 35};
    v[9] = '{MDU_MUL,   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 67};
    for (int i = 0; i < 10; i++) begin
      run_op(v[i].o, v[i].a, v[i].b, r, lat);
      n_checks++;
      if (r !== v[i].exp) begin n_fail++; $display("FAIL directed_result[%0d] got %h want %h", i, r, v[i].exp); end
      n_checks++;
      if (lat != v[i].lat) begin n_fail++; $display("FAIL directed_latency[%0d] got %0d want %0d", i, lat, v[i].lat); end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] r;
    int          lat;
    run_op(MDU_DIVUW, 64'h1_0000_0064, 64'd7, r, lat);
    n_checks++; if (r !== 64'd14) begin n_fail++; $display("FAIL b2b_first got %h want %h", r, 64'd14); end
    n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_ready got in_ready=%b busy=%b want 1/0", in_ready, busy); end
    run_op(MDU_REMUW, 64'd100, 64'd7, r, lat);
    n_checks++; if (r !== 64'd2) begin n_fail++; $display("FAIL b2b_second got %h want %h", r, 64'd2); end
    n_checks++; if (lat != 35) begin n_fail++; $display("FAIL b2b_latency got %0d want 35", lat); end
  endtask

  task automatic test_backpressure();
    logic [63:0] r0;
    bit          seen;
    issue(MDU_MULW, 64'h7FFF_FFFF, 64'd2);
    seen = 0;
    for (int k = 1; k <= 150 && !seen; k++) begin
      @(negedge clk);
      if (k == 1) in_valid = 1'b0;
      seen = out_valid;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL bp_timeout got no out_valid want out_valid within 150 cycles"); end
    r0 = result;
    n_checks++; if (r0 !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_fail++; $display("FAIL bp_value got %h want fffffffffffffffe", r0); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (result !== r0 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold[%0d] got result=%h in_ready=%b out_valid=%b want %h/0/1", i, result, in_ready, out_valid, r0);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_release got in_ready=%b busy=%b out_valid=%b want 1/0/0", in_ready, busy, out_valid);
    end
  endtask

  task automatic test_flush_mid();
    int hits;
    issue(MDU_DIV, 64'h0123_4567_89AB_CDEF, 64'd3);
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (k == 1) in_valid = 1'b0;
    end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_pre_busy got %b want 1", busy); end
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_abort got busy=%b out_valid=%b want 0/0", busy, out_valid);
    end
    hits = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (out_valid) hits++;
    end
    n_checks++; if (hits != 0) begin n_fail++; $display("FAIL flush_no_result got %0d valid cycles want 0", hits); end
  endtask

  task automatic test_rst_mid();
    issue(MDU_MUL, 64'h1234_5678, 64'h9ABC_DEF0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) in_valid = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || result !== 64'd0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid got out_valid=%b result=%h busy=%b in_ready=%b want 0/0/0/0", out_valid, result, busy, in_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_release got in_ready=%b want 1", in_ready); end
  endtask

  task automatic test_flush_accept();
    flush = 1'b1; in_valid = 1'b1; op = MDU_MUL; op_1 = 64'd3; op_2 = 64'd5;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_accept_ready got %b want 0", in_ready); end
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_accept_busy got %b want 0", busy); end
  endtask

  task automatic test_random();
    logic [63:0] a, b, r, e;
    logic [3:0]  o;
    int          lat, el;
    for (int i = 0; i < 60; i++) begin
      o = 4'($urandom_range(0, 11));
      a = pick();
      b = pick();
      e  = ref_mdu(o, a, b);
      el = ref_lat(o, a, b);
      run_op(o, a, b, r, lat);
      n_checks++;
      if (r !== e) begin n_fail++; $display("FAIL rand_result[%0d] op=%0d a=%h b=%h got %h want %h", i, o, a, b, r, e); end
      n_checks++;
      if (lat != el) begin n_fail++; $display("FAIL rand_latency[%0d] op=%0d got %0d want %0d", i, o, lat, el); end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    op = '0; op_1 = '0; op_2 = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_flush_mid();
    test_rst_mid();
    test_flush_accept();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22050019_mdu.md
# ysyx_22050019_mdu

Multi-cycle multiply/divide unit for the RV64M ops (mul, mulw, div, divu, divw, divuw, rem, remu, remw, remuw). It replaces the single-cycle `*`, `/` and `%` paths in the EXU ALU with a sequenced shift-add multiplier and a restoring divider. The EXU routes M-extension ops here through a valid/ready handshake and stalls while `busy` is high.

## Interface
- `XLEN`, default 64: operand and result width. Word ops use the low 32 bits.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: the request below is valid.
- `in_ready` out 1: the unit can accept a request.
- `op` in 4: operation code, `MDU_*` encoding from the package.
- `op_1` in XLEN: rs1 / dividend / multiplicand.
- `op_2` in XLEN: rs2 / divisor / multiplier.
- `flush` in 1: abort the in-flight op and drop its result.
- `out_valid` out 1: `result` is valid.
- `out_ready` in 1: the consumer accepts `result`.
- `result` out XLEN: final value. Word ops return the sign-extended 32-bit result.
- `busy` out 1: high in every state except IDLE.

## Operation
- **Accept.** A request is accepted when `in_valid & in_ready`. The unit latches `op`, `op_1` and `op_2`.
- **`in_ready` rule.** `in_ready = (state==IDLE) & ~flush & ~rst`.
- **FSM states and transitions.**
  - IDLE → PREP on accept.
  - PREP → DONE for a special-case divide.
  - PREP → CALC otherwise.
  - CALC → FIXUP when the iteration counter reaches N-1.
  - FIXUP → DONE.
  - DONE → IDLE on `out_ready`.
- **PREP.**
  - Signed div/rem ops: take the absolute values of the operands and record the quotient sign (`s1^s2`) and the remainder sign (`s1`).
  - Word ops: use bits [31:0] as the operands. The signed word ops first sign-extend from bit 31.
  - Load the counter with 0.
  - N = 64 for 64-bit ops, N = 32 for word ops.
- **CALC, multiply.** One bit per cycle, shift-add: if the multiplier LSB is set, add the multiplicand to the accumulator; then shift the multiplicand left and the multiplier right. Only the low XLEN bits are kept, so no sign handling is needed.
- **CALC, divide.** One quotient bit per cycle, restoring:
  - Form `rem = {rem[XLEN-2:0], dividend MSB}`.
  - If `rem >= divisor`: subtract the divisor and shift in a quotient bit of 1.
  - Otherwise shift in a quotient bit of 0.
- **FIXUP.**
  - Negate the quotient and/or remainder according to the recorded signs.
  - Select the quotient or the remainder according to `op`.
  - Word ops: `result = {{32{r[31]}}, r[31:0]}`.
- **Special cases, resolved in PREP and skipping CALC:**
  - Divide by zero: quotient is all ones (sign-extended for word ops); remainder is the dividend (sign-extended `op_1[31:0]` for word ops).
  - Signed overflow (most-negative value / -1, at 64- or 32-bit width): quotient is the most-negative value, remainder is 0.
- **DONE.**
  - `out_valid=1`.
  - `result` is held stable until `out_ready`.
  - No new request is accepted in DONE.
- **Flush.** A synchronous `flush` in any state forces IDLE on the next cycle, with `out_valid=0` and the partial state discarded. If `flush` and `in_valid` are high together, the request is not accepted.
- **Reset.** A synchronous `rst` has the same effect as `flush`, and also clears `result` to 0 and the counter to 0.

## Timing
- **Reset values.**
  - Outputs: `out_valid=0`, `result=0`, `busy=0`; `in_ready=0` while `rst` is high and 1 in the cycle after.
  - Internal: `state=IDLE`.
- **Latency.** Accept is at the edge ending cycle T. PREP occupies T+1.
  - Normal ops: CALC occupies T+2..T+1+N, FIXUP occupies T+2+N, and `out_valid` rises at T+3+N. This gives 67 cycles for 64-bit ops and 35 for word ops.
  - Special cases: `out_valid` at T+2.
- **Latency is fixed.** There is no early termination for multiply-by-zero or small operands.
- **Throughput.** One op in flight. The earliest next accept is the cycle after the DONE handshake.
- **Registered outputs.** `result` and `out_valid` are registered. `in_ready` and `busy` are decoded from the state.

## Structure
- Package `ysyx_22050019_mdu_pkg` holds:
  - the `MDU_*` 4-bit op encodings (MUL=0, MULW=1, DIV=2, DIVU=3, DIVW=4, DIVUW=5, REM=6, REMU=7, REMW=8, REMUW=9; all other values are reserved and return 0 via the normal path);
  - the state enum `{IDLE, PREP, CALC, FIXUP, DONE}`;
  - the XLEN constant.
- Sub-module `ysyx_22050019_mdu_step` is the combinational one-iteration datapath. It covers both the shift-add step and the compare-subtract-shift step, selected by an `is_div` input.
- The top level holds the FSM, the counter, the operand, sign and accumulator registers, and FIXUP.

## Test plan
- div `op_1=0xFFFF_FFFF_FFFF_FFF9` (-7), `op_2=2` → `result=0xFFFF_FFFF_FFFF_FFFD` with `out_valid` at T+67. rem on the same operands → `0xFFFF_FFFF_FFFF_FFFF`.
- divu `op_1=0x1234`, `op_2=0` → `0xFFFF_FFFF_FFFF_FFFF` at T+2. remu on the same operands → `0x1234`. remw with `op_1=0x8000_0001`, `op_2=0` → `0xFFFF_FFFF_8000_0001`.
- Signed overflow:
  - div `0x8000_0000_0000_0000 / 0xFFFF_FFFF_FFFF_FFFF` → `0x8000_0000_0000_0000` at T+2, and rem → 0.
  - divw `0x8000_0000 / 0xFFFF_FFFF` → `0xFFFF_FFFF_8000_0000`.
- mulw `0x7FFF_FFFF * 2` → `0xFFFF_FFFF_FFFF_FFFE` at T+35. mul `0xFFFF_FFFF_FFFF_FFFF * 0xFFFF_FFFF_FFFF_FFFF` → 1 at T+67.
- Backpressure: hold `out_ready=0` for 10 cycles in DONE → `result` is stable and `in_ready=0`. Then raise `out_ready` → IDLE and `in_ready=1` on the next cycle.
- Abort cases:
  - Assert `flush` at CALC iteration 20 → `busy=0` and `out_valid=0` on the next cycle, and no result appears.
  - Assert `rst` mid-CALC → the reset values above hold.
  - Raise `flush` together with `in_valid` in IDLE → no accept.
